pong_match_ctrl: RTL and testbench

- Match-level sequencer for the VGA Pong datapath.
- Holds the ball at centre through serve and post-point delays, and counts player/computer points from the ball block's scoring flags.
- Declares a winner at WIN_SCORE and gates paddle movement.
- Sits between the top level, the ball block (drives its reset) and the paddle blocks (drives their enable).

---
 rtl/pong_match_ctrl_if.sv | 40 ++++
 rtl/pong_match_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if
//   Groups the match controller's per-frame inputs and its status outputs
//   into one bundle.
//   master : top-level side. Drives frameTick, start, PScore and CScore,
//            and observes the controller outputs.
//   slave  : the match controller itself.
//   Signals:
//     frameTick       one-cycle pulse per video frame
//     start           debounced start button (level)
//     PScore, CScore  scoring flags from the ball block
//     ballRst         1 = hold the ball at centre
//     paddleEn        enables paddle movement
//     PPoints/CPoints player/computer point counts
//     win, pWin       match over / player is the winner
//     state           current FSM state encoding
interface pong_match_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               frameTick;
    logic               start;
    logic               PScore;
    logic               CScore;
    logic               ballRst;
    logic               paddleEn;
    logic [SCORE_W-1:0] PPoints;
    logic [SCORE_W-1:0] CPoints;
    logic               win;
    logic               pWin;
    logic [2:0]         state;

    modport master (
        output frameTick, start, PScore, CScore,
        input  ballRst, paddleEn, PPoints, CPoints, win, pWin, state
    );

    modport slave (
        input  frameTick, start, PScore, CScore,
        output ballRst, paddleEn, PPoints, CPoints, win, pWin, state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
//   Match-level sequencer for the Pong datapath. It holds the ball at
//   centre during the serve and post-point delays, counts points from the
//   ball block's scoring flags, declares a winner at WIN_SCORE and gates
//   paddle movement.
//   Ports:
//     clkG   system clock, rising edge
//     Reset  asynchronous, active-high reset
//     bus    pong_match_ctrl_if.slave (inputs frameTick/start/PScore/CScore,
//            outputs ballRst/paddleEn/PPoints/CPoints/win/pWin/state)
//   Build option:
//     PONG_SCORE_SYNC_EN  when defined, start/PScore/CScore each pass
//                         through a 2-flop synchronizer before edge
//                         detection (action 3 clkG edges after the input
//                         rises instead of 1).
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4,
    parameter int SERVE_TICKS = 120,
    parameter int POINT_TICKS = 60,
    parameter int TMR_W       = 8
) (
    input  logic              clkG,
    input  logic              Reset,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_CNT    = SCORE_W'(WIN_SCORE);
    localparam logic [TMR_W-1:0]   SERVE_LOAD = TMR_W'(SERVE_TICKS);
    localparam logic [TMR_W-1:0]   POINT_LOAD = TMR_W'(POINT_TICKS);
    localparam logic [TMR_W-1:0]   TMR_ONE    = TMR_W'(1);

    state_t             state_q, state_n;
    logic [TMR_W-1:0]   timer_q, timer_n;
    logic [SCORE_W-1:0] ppoints_q, ppoints_n, cpoints_q, cpoints_n;
    logic [SCORE_W-1:0] ppoints_inc, cpoints_inc;
    logic               win_q, win_n, pwin_q, pwin_n;
    logic               ball_rst_q, ball_rst_n, paddle_en_q, paddle_en_n;

    logic start_in, pscore_in, cscore_in;
    logic start_d, pscore_d, cscore_d;
    logic start_rise, pscore_rise, cscore_rise;

`ifdef PONG_SCORE_SYNC_EN
    // Two-flop synchronizers for inputs that may come from the ball clock.
    logic [1:0] start_sync, pscore_sync, cscore_sync;

    always_ff @(posedge clkG or posedge Reset) begin
        if (Reset) begin
            start_sync  <= 2'b00;
            pscore_sync <= 2'b00;
            cscore_sync <= 2'b00;
        end else begin
            start_sync  <= {start_sync[0],  bus.start};
            pscore_sync <= {pscore_sync[0], bus.PScore};
            cscore_sync <= {cscore_sync[0], bus.CScore};
        end
    end

    assign start_in  = start_sync[1];
    assign pscore_in = pscore_sync[1];
    assign cscore_in = cscore_sync[1];
`else
    assign start_in  = bus.start;
    assign pscore_in = bus.PScore;
    assign cscore_in = bus.CScore;
`endif

    // Edge detectors update every cycle regardless of state, so a flag that
    // is already high when PLAY is entered does not count as a new point.
    always_ff @(posedge clkG or posedge Reset) begin
        if (Reset) begin
            start_d  <= 1'b0;
            pscore_d <= 1'b0;
            cscore_d <= 1'b0;
        end else begin
            start_d  <= start_in;
            pscore_d <= pscore_in;
            cscore_d <= cscore_in;
        end
    end

    assign start_rise  = start_in  & ~start_d;
    assign pscore_rise = pscore_in & ~pscore_d;
    assign cscore_rise = cscore_in & ~cscore_d;

    // Counts never pass WIN_SCORE, so these sums cannot wrap.
    assign ppoints_inc = ppoints_q + SCORE_W'(pscore_rise);
    assign cpoints_inc = cpoints_q + SCORE_W'(cscore_rise);

    always_ff @(posedge clkG or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            ppoints_q   <= '0;
            cpoints_q   <= '0;
            win_q       <= 1'b0;
            pwin_q      <= 1'b0;
            ball_rst_q  <= 1'b1;
            paddle_en_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            timer_q     <= timer_n;
            ppoints_q   <= ppoints_n;
            cpoints_q   <= cpoints_n;
            win_q       <= win_n;
            pwin_q      <= pwin_n;
            ball_rst_q  <= ball_rst_n;
            paddle_en_q <= paddle_en_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        ppoints_n = ppoints_q;
        cpoints_n = cpoints_q;
        win_n     = win_q;
        pwin_n    = pwin_q;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    ppoints_n = '0;
                    cpoints_n = '0;
                    timer_n   = SERVE_LOAD;
                    state_n   = SERVE;
                end
            end
            // The timer is loaded on entry and only counts frameTicks seen
            // while already in the state, so the delay is exactly N frames.
            SERVE, POINT: begin
                if (bus.frameTick) begin
                    if (timer_q == TMR_ONE) begin
                        state_n = PLAY;
                    end else begin
                        timer_n = timer_q - TMR_ONE;
                    end
                end
            end
            PLAY: begin
                if (pscore_rise || cscore_rise) begin
                    ppoints_n = ppoints_inc;
                    cpoints_n = cpoints_inc;
                    if ((ppoints_inc == WIN_CNT) || (cpoints_inc == WIN_CNT)) begin
                        state_n = OVER;
                        win_n   = 1'b1;
                        // Player takes a simultaneous tie at WIN_SCORE.
                        pwin_n  = (ppoints_inc == WIN_CNT);
                    end else begin
                        timer_n = POINT_LOAD;
                        state_n = POINT;
                    end
                end
            end
            OVER: begin
                if (start_rise) begin
                    ppoints_n = '0;
                    cpoints_n = '0;
                    win_n     = 1'b0;
                    pwin_n    = 1'b0;
                    timer_n   = SERVE_LOAD;
                    state_n   = SERVE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Moore outputs are registered by decoding the next state.
    always_comb begin
        ball_rst_n  = 1'b1;
        paddle_en_n = 1'b0;
        case (state_n)
            SERVE:   paddle_en_n = 1'b1;
            PLAY: begin
                ball_rst_n  = 1'b0;
                paddle_en_n = 1'b1;
            end
            POINT:   paddle_en_n = 1'b1;
            default: begin
                ball_rst_n  = 1'b1;
                paddle_en_n = 1'b0;
            end
        endcase
    end

    assign bus.state    = state_q;
    assign bus.ballRst  = ball_rst_q;
    assign bus.paddleEn = paddle_en_q;
    assign bus.PPoints  = ppoints_q;
    assign bus.CPoints  = cpoints_q;
    assign bus.win      = win_q;
    assign bus.pWin     = pwin_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl
//   Scoreboard bench for pong_match_ctrl with WIN_SCORE=3, SERVE_TICKS=2,
//   POINT_TICKS=2. The stimulus thread pushes the expected output snapshot
//   for every output change it causes; a monitor compares each observed
//   change against the head of the queue.
module tb_pong_match_ctrl;

    typedef struct {
        logic [14:0] v;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic mon_en;
    logic armed;
    logic [14:0] prev;
    exp_t q[$];

    pong_match_ctrl_if #(.SCORE_W(4)) bus ();

    pong_match_ctrl #(
        .WIN_SCORE  (3),
        .SCORE_W    (4),
        .SERVE_TICKS(2),
        .POINT_TICKS(2),
        .TMR_W      (8)
    ) dut (
        .clkG (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected snapshot built from the state table.
    function automatic logic [14:0] mk(input logic [2:0] st, input logic [3:0] pp,
                                       input logic [3:0] cp, input logic w, input logic pw);
        logic br, pe;
        br = (st != 3'd2);
        pe = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
        return {st, br, pe, pp, cp, w, pw};
    endfunction

    function automatic logic [14:0] snap();
        return {bus.state, bus.ballRst, bus.paddleEn, bus.PPoints, bus.CPoints, bus.win, bus.pWin};
    endfunction

    task automatic expect_out(input string name, input logic [2:0] st, input logic [3:0] pp,
                              input logic [3:0] cp, input logic w, input logic pw);
        exp_t e;
        e.v = mk(st, pp, cp, w, pw);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ft();
        bus.frameTick = 1'b1;
        cyc(1);
        bus.frameTick = 1'b0;
        cyc(1);
    endtask

    task automatic ft2();
        pulse_ft();
        pulse_ft();
    endtask

    task automatic score(input logic p, input logic c, input int len);
        bus.PScore = p;
        bus.CScore = c;
        cyc(len);
        bus.PScore = 1'b0;
        bus.CScore = 1'b0;
        cyc(1);
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(1);
    endtask

    // Monitor: every observed change of the output vector must match the
    // next expected snapshot.
    always @(negedge clk) begin
        logic [14:0] cur;
        exp_t e;
        if (mon_en) begin
            cur = snap();
            if (!armed) begin
                prev  = cur;
                armed = 1'b1;
            end else if (cur !== prev) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: got %h required no change from %h", cur, prev);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.v) begin
                        fails++;
                        $display("FAIL %s: got %h required %h", e.name, cur, e.v);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] r;
        tests = 0;
        fails = 0;
        mon_en = 1'b0;
        armed  = 1'b0;
        prev   = '0;
        rst = 1'b1;
        bus.frameTick = 1'b0;
        bus.start     = 1'b0;
        bus.PScore    = 1'b0;
        bus.CScore    = 1'b0;
        cyc(3);

        tests++;
        r = snap();
        if (r !== mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0)) begin
            fails++;
            $display("FAIL reset_state: got %h required %h", r, mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        cyc(1);
        mon_en = 1'b1;
        cyc(2);

        // Serve then play.
        expect_out("idle_to_serve", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        start_pulse();
        expect_out("serve_to_play", 3'd2, 4'd0, 4'd0, 1'b0, 1'b0);
        ft2();

        // Long PScore gives a single point.
        expect_out("p_long_pulse", 3'd3, 4'd1, 4'd0, 1'b0, 1'b0);
        score(1'b1, 1'b0, 5);
        expect_out("point_to_play_1", 3'd2, 4'd1, 4'd0, 1'b0, 1'b0);
        ft2();

        expect_out("c_point", 3'd3, 4'd1, 4'd1, 1'b0, 1'b0);
        score(1'b0, 1'b1, 1);
        expect_out("point_to_play_2", 3'd2, 4'd1, 4'd1, 1'b0, 1'b0);
        ft2();

        // Simultaneous points at 1-1, then a score inside POINT is ignored.
        expect_out("both_at_1_1", 3'd3, 4'd2, 4'd2, 1'b0, 1'b0);
        score(1'b1, 1'b1, 1);
        score(1'b1, 1'b0, 1);
        expect_out("point_to_play_3", 3'd2, 4'd2, 4'd2, 1'b0, 1'b0);
        ft2();

        // Asynchronous reset in PLAY.
        expect_out("async_reset_mon", 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        tests++;
        r = snap();
        if (r !== mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0)) begin
            fails++;
            $display("FAIL async_reset_now: got %h required %h", r, mk(3'd0, 4'd0, 4'd0, 1'b0, 1'b0));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);

        // Game 2: tie at 3-3 goes to the player; start held across OVER.
        expect_out("g2_serve", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        start_pulse();
        expect_out("g2_play", 3'd2, 4'd0, 4'd0, 1'b0, 1'b0);
        ft2();
        expect_out("g2_both_1", 3'd3, 4'd1, 4'd1, 1'b0, 1'b0);
        score(1'b1, 1'b1, 1);
        expect_out("g2_play_a", 3'd2, 4'd1, 4'd1, 1'b0, 1'b0);
        ft2();
        expect_out("g2_both_2", 3'd3, 4'd2, 4'd2, 1'b0, 1'b0);
        score(1'b1, 1'b1, 1);
        expect_out("g2_play_b", 3'd2, 4'd2, 4'd2, 1'b0, 1'b0);
        ft2();
        bus.start = 1'b1;
        cyc(2);
        expect_out("g2_tie_win", 3'd4, 4'd3, 4'd3, 1'b1, 1'b1);
        score(1'b1, 1'b1, 1);
        cyc(3);
        score(1'b1, 1'b0, 1);
        score(1'b0, 1'b1, 1);
        bus.start = 1'b0;
        cyc(2);

        // Restart from OVER; scores in SERVE ignored; player wins 3-1.
        expect_out("g3_restart", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        start_pulse();
        score(1'b1, 1'b0, 1);
        score(1'b0, 1'b1, 1);
        expect_out("g3_play", 3'd2, 4'd0, 4'd0, 1'b0, 1'b0);
        ft2();
        expect_out("g3_p1", 3'd3, 4'd1, 4'd0, 1'b0, 1'b0);
        score(1'b1, 1'b0, 1);
        expect_out("g3_play_a", 3'd2, 4'd1, 4'd0, 1'b0, 1'b0);
        ft2();
        expect_out("g3_p2", 3'd3, 4'd2, 4'd0, 1'b0, 1'b0);
        score(1'b1, 1'b0, 1);
        expect_out("g3_play_b", 3'd2, 4'd2, 4'd0, 1'b0, 1'b0);
        ft2();
        expect_out("g3_c1", 3'd3, 4'd2, 4'd1, 1'b0, 1'b0);
        score(1'b0, 1'b1, 1);
        expect_out("g3_play_c", 3'd2, 4'd2, 4'd1, 1'b0, 1'b0);
        ft2();
        expect_out("g3_p_win", 3'd4, 4'd3, 4'd1, 1'b1, 1'b1);
        score(1'b1, 1'b0, 1);
        score(1'b1, 1'b0, 1);
        cyc(2);

        // Game 4: computer wins 0-3.
        expect_out("g4_restart", 3'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        start_pulse();
        expect_out("g4_play", 3'd2, 4'd0, 4'd0, 1'b0, 1'b0);
        ft2();
        expect_out("g4_c1", 3'd3, 4'd0, 4'd1, 1'b0, 1'b0);
        score(1'b0, 1'b1, 1);
        expect_out("g4_play_a", 3'd2, 4'd0, 4'd1, 1'b0, 1'b0);
        ft2();
        expect_out("g4_c2", 3'd3, 4'd0, 4'd2, 1'b0, 1'b0);
        score(1'b0, 1'b1, 1);
        expect_out("g4_play_b", 3'd2, 4'd0, 4'd2, 1'b0, 1'b0);
        ft2();
        expect_out("g4_c_win", 3'd4, 4'd0, 4'd3, 1'b1, 1'b0);
        score(1'b0, 1'b1, 1);
        cyc(5);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations: got %0d outstanding required 0 (next %s)",
                     q.size(), q[0].name);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
